// File: rtl/fc_pkg.sv
// Shared types and constants for the pipeline flow controller.
package fc_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    MEM_WAIT = 2'd2,
    MDU_WAIT = 2'd3
  } fc_state_e;

  // Bubble contents seen by the pipeline registers: addi x0,x0,0 writing x0.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  // True when a source operand read in ID matches a non-zero EX destination.
  function automatic logic src_match(input logic re, input logic [4:0] rs,
                                     input logic [4:0] rd);
    return re && (rs == rd) && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/flow_ctrl_if.sv
// Pipeline <-> flow-controller signal bundle. The pipeline is the master,
// the flow controller the slave.
interface flow_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       id_rs1_addr_i;
  logic             id_rs1_re_i;
  logic [4:0]       id_rs2_addr_i;
  logic             id_rs2_re_i;
  logic             id_jump_i;
  logic [31:0]      id_jump_target_i;
  logic             ex_is_load_i;
  logic [4:0]       ex_rd_addr_i;
  logic             ex_branch_taken_i;
  logic [31:0]      ex_branch_target_i;
  logic             mem_req_i;
  logic             mem_ready_i;
  logic             mdu_start_i;
  logic             mdu_done_i;
  logic             fc_stall_flag_o;
  logic             fc_flush_btype_flag_o;
  logic             fc_flush_jtype_flag_o;
  logic             fc_idex_bubble_o;
  logic             fc_freeze_ex_o;
  logic             fc_redirect_o;
  logic [31:0]      fc_redirect_pc_o;
  logic             fc_mem_timeout_o;
  logic [CNT_W-1:0] fc_stall_cnt_o;

  modport master (
    output id_rs1_addr_i, id_rs1_re_i, id_rs2_addr_i, id_rs2_re_i,
           id_jump_i, id_jump_target_i, ex_is_load_i, ex_rd_addr_i,
           ex_branch_taken_i, ex_branch_target_i, mem_req_i, mem_ready_i,
           mdu_start_i, mdu_done_i,
    input  fc_stall_flag_o, fc_flush_btype_flag_o, fc_flush_jtype_flag_o,
           fc_idex_bubble_o, fc_freeze_ex_o, fc_redirect_o, fc_redirect_pc_o,
           fc_mem_timeout_o, fc_stall_cnt_o
  );

  modport slave (
    input  id_rs1_addr_i, id_rs1_re_i, id_rs2_addr_i, id_rs2_re_i,
           id_jump_i, id_jump_target_i, ex_is_load_i, ex_rd_addr_i,
           ex_branch_taken_i, ex_branch_target_i, mem_req_i, mem_ready_i,
           mdu_start_i, mdu_done_i,
    output fc_stall_flag_o, fc_flush_btype_flag_o, fc_flush_jtype_flag_o,
           fc_idex_bubble_o, fc_freeze_ex_o, fc_redirect_o, fc_redirect_pc_o,
           fc_mem_timeout_o, fc_stall_cnt_o
  );
endinterface

// File: rtl/fc_hazard_detect.sv
// Load-use comparator: a load in EX whose destination is read by ID.
module fc_hazard_detect
  import fc_pkg::*;
(
  input  logic [4:0] id_rs1_addr,
  input  logic       id_rs1_re,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs2_re,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd_addr,
  output logic       hz
);

  // x0 is never a real dependency, src_match filters it out.
  assign hz = ex_is_load &&
              (src_match(id_rs1_re, id_rs1_addr, ex_rd_addr) ||
               src_match(id_rs2_re, id_rs2_addr, ex_rd_addr));

endmodule

// File: rtl/flow_ctrl.sv
// Pipeline flow controller: stall/flush/bubble/freeze/redirect generation,
// stall-cycle statistics and a sticky data-memory timeout flag.
module flow_ctrl
  import fc_pkg::*;
#(
  parameter int LU_STALL    = 1,
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  flow_ctrl_if.slave fc
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(MEM_TIMEOUT);
  localparam logic [2:0]      LU_LOAD = 3'(LU_STALL - 1);

  fc_state_e        state_q, state_d;
  logic [2:0]       lu_q, lu_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             hz, run_rules;
  logic             stall, flush_b, flush_j, bubble, freeze, redirect;
  logic [31:0]      redirect_pc;

  fc_hazard_detect u_hz (
    .id_rs1_addr (fc.id_rs1_addr_i),
    .id_rs1_re   (fc.id_rs1_re_i),
    .id_rs2_addr (fc.id_rs2_addr_i),
    .id_rs2_re   (fc.id_rs2_re_i),
    .ex_is_load  (fc.ex_is_load_i),
    .ex_rd_addr  (fc.ex_rd_addr_i),
    .hz          (hz)
  );

  // Flag generation and next-state; wait states fall through to RUN rules on release.
  always_comb begin
    stall       = 1'b0;
    flush_b     = 1'b0;
    flush_j     = 1'b0;
    bubble      = 1'b0;
    freeze      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    state_d     = state_q;
    lu_d        = lu_q;
    to_d        = to_q;
    run_rules   = 1'b0;

    unique case (state_q)
      RUN: run_rules = 1'b1;
      LOAD_USE: begin
        stall  = 1'b1;
        bubble = 1'b1;
        lu_d   = lu_q - 3'd1;
        if (lu_q <= 3'd1) state_d = RUN;
      end
      MEM_WAIT: begin
        if (fc.mem_ready_i) begin
          run_rules = 1'b1;
          to_d      = '0;
        end else begin
          stall  = 1'b1;
          freeze = 1'b1;
          if (to_q != TO_MAX) to_d = to_q + 1'b1;
        end
      end
      MDU_WAIT: begin
        if (fc.mdu_done_i) begin
          run_rules = 1'b1;
        end else begin
          stall  = 1'b1;
          freeze = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    // A frozen EX keeps a taken branch asserted, so the flush lands on release.
    if (run_rules) begin
      state_d = RUN;
      if (fc.mem_req_i && !fc.mem_ready_i) begin
        stall   = 1'b1;
        freeze  = 1'b1;
        to_d    = TO_W'(1);
        state_d = MEM_WAIT;
      end else if (fc.ex_branch_taken_i) begin
        flush_b     = 1'b1;
        bubble      = 1'b1;
        redirect    = 1'b1;
        redirect_pc = fc.ex_branch_target_i;
      end else if (hz) begin
        stall  = 1'b1;
        bubble = 1'b1;
        if (LU_STALL > 1) begin
          lu_d    = LU_LOAD;
          state_d = LOAD_USE;
        end
      end else if (fc.id_jump_i) begin
        flush_j     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = fc.id_jump_target_i;
      end else if (fc.mdu_start_i && !fc.mdu_done_i) begin
        stall   = 1'b1;
        freeze  = 1'b1;
        state_d = MDU_WAIT;
      end
    end
  end

  // State, counters and the sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      lu_q        <= '0;
      to_q        <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      lu_q    <= lu_d;
      to_q    <= to_d;
      if (to_d == TO_MAX) timeout_q <= 1'b1;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign fc.fc_stall_flag_o       = stall;
  assign fc.fc_flush_btype_flag_o = flush_b;
  assign fc.fc_flush_jtype_flag_o = flush_j;
  assign fc.fc_idex_bubble_o      = bubble;
  assign fc.fc_freeze_ex_o        = freeze;
  assign fc.fc_redirect_o         = redirect;
  assign fc.fc_redirect_pc_o      = redirect_pc;
  assign fc.fc_mem_timeout_o      = timeout_q;
  assign fc.fc_stall_cnt_o        = stall_cnt_q;

endmodule

// File: tb/tb_flow_ctrl.sv
// Directed bench for flow_ctrl. Two instances share stimulus: LU_STALL=1 (a)
// and LU_STALL=3 (b), both with MEM_TIMEOUT=8.
module tb_flow_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  flow_ctrl_if #(.CNT_W(32)) ifa ();
  flow_ctrl_if #(.CNT_W(32)) ifb ();

  flow_ctrl #(.LU_STALL(1), .MEM_TIMEOUT(8), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .fc(ifa.slave));
  flow_ctrl #(.LU_STALL(3), .MEM_TIMEOUT(8), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .fc(ifb.slave));

  assign ifb.id_rs1_addr_i      = ifa.id_rs1_addr_i;
  assign ifb.id_rs1_re_i        = ifa.id_rs1_re_i;
  assign ifb.id_rs2_addr_i      = ifa.id_rs2_addr_i;
  assign ifb.id_rs2_re_i        = ifa.id_rs2_re_i;
  assign ifb.id_jump_i          = ifa.id_jump_i;
  assign ifb.id_jump_target_i   = ifa.id_jump_target_i;
  assign ifb.ex_is_load_i       = ifa.ex_is_load_i;
  assign ifb.ex_rd_addr_i       = ifa.ex_rd_addr_i;
  assign ifb.ex_branch_taken_i  = ifa.ex_branch_taken_i;
  assign ifb.ex_branch_target_i = ifa.ex_branch_target_i;
  assign ifb.mem_req_i          = ifa.mem_req_i;
  assign ifb.mem_ready_i        = ifa.mem_ready_i;
  assign ifb.mdu_start_i        = ifa.mdu_start_i;
  assign ifb.mdu_done_i         = ifa.mdu_done_i;

  // Flag vectors: {stall, flush_b, flush_j, bubble, freeze, redirect}
  wire [5:0] fa = {ifa.fc_stall_flag_o, ifa.fc_flush_btype_flag_o,
                   ifa.fc_flush_jtype_flag_o, ifa.fc_idex_bubble_o,
                   ifa.fc_freeze_ex_o, ifa.fc_redirect_o};
  wire [5:0] fb = {ifb.fc_stall_flag_o, ifb.fc_flush_btype_flag_o,
                   ifb.fc_flush_jtype_flag_o, ifb.fc_idex_bubble_o,
                   ifb.fc_freeze_ex_o, ifb.fc_redirect_o};

  task automatic idle();
    ifa.id_rs1_addr_i = '0; ifa.id_rs1_re_i = 1'b0;
    ifa.id_rs2_addr_i = '0; ifa.id_rs2_re_i = 1'b0;
    ifa.id_jump_i = 1'b0; ifa.id_jump_target_i = '0;
    ifa.ex_is_load_i = 1'b0; ifa.ex_rd_addr_i = '0;
    ifa.ex_branch_taken_i = 1'b0; ifa.ex_branch_target_i = '0;
    ifa.mem_req_i = 1'b0; ifa.mem_ready_i = 1'b0;
    ifa.mdu_start_i = 1'b0; ifa.mdu_done_i = 1'b0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    next(); next();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #3;
    nvec++; if (fa !== 6'b0) begin nerr++; $display("FAIL reset_flags: got %b want 000000", fa); end
    nvec++; if (ifa.fc_redirect_pc_o !== 32'd0) begin nerr++; $display("FAIL reset_pc: got %h want 0", ifa.fc_redirect_pc_o); end
    nvec++; if (ifa.fc_stall_cnt_o !== 32'd0) begin nerr++; $display("FAIL reset_cnt: got %0d want 0", ifa.fc_stall_cnt_o); end
    nvec++; if (ifa.fc_mem_timeout_o !== 1'b0) begin nerr++; $display("FAIL reset_to: got %b want 0", ifa.fc_mem_timeout_o); end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    next();
    ifa.ex_is_load_i = 1'b1; ifa.ex_rd_addr_i = 5'd5;
    ifa.id_rs1_addr_i = 5'd5; ifa.id_rs1_re_i = 1'b1;
    @(negedge clk);
    nvec++; if (fa !== 6'b100100) begin nerr++; $display("FAIL lu_a_c0: got %b want 100100", fa); end
    nvec++; if (fb !== 6'b100100) begin nerr++; $display("FAIL lu_b_c0: got %b want 100100", fb); end
    next(); idle();
    @(negedge clk);
    nvec++; if (fa !== 6'b000000) begin nerr++; $display("FAIL lu_a_release: got %b want 000000", fa); end
    nvec++; if (fb !== 6'b100100) begin nerr++; $display("FAIL lu_b_c1: got %b want 100100", fb); end
    nvec++; if (ifa.fc_stall_cnt_o !== 32'd1) begin nerr++; $display("FAIL lu_a_cnt: got %0d want 1", ifa.fc_stall_cnt_o); end
    next();
    @(negedge clk);
    nvec++; if (fb !== 6'b100100) begin nerr++; $display("FAIL lu_b_c2: got %b want 100100", fb); end
    next();
    @(negedge clk);
    nvec++; if (fb !== 6'b000000) begin nerr++; $display("FAIL lu_b_release: got %b want 000000", fb); end
    nvec++; if (ifb.fc_stall_cnt_o !== 32'd3) begin nerr++; $display("FAIL lu_b_cnt: got %0d want 3", ifb.fc_stall_cnt_o); end
    // rd = x0 never stalls
    next();
    ifa.ex_is_load_i = 1'b1; ifa.ex_rd_addr_i = 5'd0;
    ifa.id_rs1_addr_i = 5'd0; ifa.id_rs1_re_i = 1'b1;
    ifa.id_rs2_addr_i = 5'd0; ifa.id_rs2_re_i = 1'b1;
    @(negedge clk);
    nvec++; if (fa !== 6'b000000) begin nerr++; $display("FAIL lu_rd0: got %b want 000000", fa); end
    // rs2 match, rs1 not enabled
    next();
    ifa.ex_rd_addr_i = 5'd7; ifa.id_rs1_addr_i = 5'd7; ifa.id_rs1_re_i = 1'b0;
    ifa.id_rs2_addr_i = 5'd7; ifa.id_rs2_re_i = 1'b1;
    @(negedge clk);
    nvec++; if (fa !== 6'b100100) begin nerr++; $display("FAIL lu_rs2: got %b want 100100", fa); end
    // matching rs1 without read enable, non-matching rs2
    next();
    ifa.id_rs2_addr_i = 5'd3;
    @(negedge clk);
    nvec++; if (fa !== 6'b000000) begin nerr++; $display("FAIL lu_no_re: got %b want 000000", fa); end
    // non-load never stalls
    next();
    ifa.ex_is_load_i = 1'b0; ifa.id_rs1_re_i = 1'b1;
    @(negedge clk);
    nvec++; if (fa !== 6'b000000) begin nerr++; $display("FAIL lu_noload: got %b want 000000", fa); end
  endtask

  task automatic test_branch_vs_jump();
    do_reset();
    next();
    ifa.ex_branch_taken_i = 1'b1; ifa.ex_branch_target_i = 32'h100;
    ifa.id_jump_i = 1'b1; ifa.id_jump_target_i = 32'h200;
    ifa.ex_is_load_i = 1'b1; ifa.ex_rd_addr_i = 5'd5;
    ifa.id_rs1_addr_i = 5'd5; ifa.id_rs1_re_i = 1'b1;
    @(negedge clk);
    nvec++; if (fa !== 6'b010101) begin nerr++; $display("FAIL bj_flags: got %b want 010101", fa); end
    nvec++; if (ifa.fc_redirect_pc_o !== 32'h100) begin nerr++; $display("FAIL bj_pc: got %h want 100", ifa.fc_redirect_pc_o); end
    next(); idle();
    ifa.id_jump_i = 1'b1; ifa.id_jump_target_i = 32'h200;
    @(negedge clk);
    nvec++; if (fa !== 6'b001001) begin nerr++; $display("FAIL jump_flags: got %b want 001001", fa); end
    nvec++; if (ifa.fc_redirect_pc_o !== 32'h200) begin nerr++; $display("FAIL jump_pc: got %h want 200", ifa.fc_redirect_pc_o); end
    next();
    ifa.ex_is_load_i = 1'b1; ifa.ex_rd_addr_i = 5'd9;
    ifa.id_rs2_addr_i = 5'd9; ifa.id_rs2_re_i = 1'b1;
    @(negedge clk);
    nvec++; if (fa !== 6'b100100) begin nerr++; $display("FAIL lu_over_jump: got %b want 100100", fa); end
    nvec++; if (ifa.fc_redirect_pc_o !== 32'h0) begin nerr++; $display("FAIL lu_over_jump_pc: got %h want 0", ifa.fc_redirect_pc_o); end
    next(); idle();
    ifa.id_jump_target_i = 32'h200; ifa.ex_branch_target_i = 32'h100;
    @(negedge clk);
    nvec++; if (ifa.fc_redirect_pc_o !== 32'h0) begin nerr++; $display("FAIL idle_pc: got %h want 0", ifa.fc_redirect_pc_o); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      next();
      ifa.mem_req_i = 1'b1; ifa.mem_ready_i = 1'b0;
      ifa.ex_branch_taken_i = 1'b1; ifa.ex_branch_target_i = 32'h180;
      @(negedge clk);
      nvec++; if (fa !== 6'b100010) begin nerr++; $display("FAIL mem_wait_c%0d: got %b want 100010", i, fa); end
    end
    next();
    ifa.mem_ready_i = 1'b1;
    @(negedge clk);
    nvec++; if (fa !== 6'b010101) begin nerr++; $display("FAIL mem_release: got %b want 010101", fa); end
    nvec++; if (ifa.fc_redirect_pc_o !== 32'h180) begin nerr++; $display("FAIL mem_release_pc: got %h want 180", ifa.fc_redirect_pc_o); end
    nvec++; if (ifa.fc_stall_cnt_o !== 32'd4) begin nerr++; $display("FAIL mem_cnt: got %0d want 4", ifa.fc_stall_cnt_o); end
    next(); idle();
    @(negedge clk);
    nvec++; if (fa !== 6'b000000) begin nerr++; $display("FAIL mem_after: got %b want 000000", fa); end
    nvec++; if (ifa.fc_stall_cnt_o !== 32'd4) begin nerr++; $display("FAIL mem_cnt_hold: got %0d want 4", ifa.fc_stall_cnt_o); end
  endtask

  task automatic test_timeout();
    logic exp_to;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      next();
      ifa.mem_req_i = 1'b1; ifa.mem_ready_i = 1'b0;
      @(negedge clk);
      exp_to = (i >= 8);
      nvec++; if (ifa.fc_mem_timeout_o !== exp_to) begin nerr++; $display("FAIL to_c%0d: got %b want %b", i, ifa.fc_mem_timeout_o, exp_to); end
      nvec++; if (fa !== 6'b100010) begin nerr++; $display("FAIL to_wait_c%0d: got %b want 100010", i, fa); end
    end
    next();
    ifa.mem_ready_i = 1'b1;
    @(negedge clk);
    nvec++; if (fa !== 6'b000000) begin nerr++; $display("FAIL to_release: got %b want 000000", fa); end
    nvec++; if (ifa.fc_mem_timeout_o !== 1'b1) begin nerr++; $display("FAIL to_sticky: got %b want 1", ifa.fc_mem_timeout_o); end
    next(); idle();
    @(negedge clk);
    nvec++; if (ifa.fc_mem_timeout_o !== 1'b1) begin nerr++; $display("FAIL to_sticky_idle: got %b want 1", ifa.fc_mem_timeout_o); end
    rst_n = 1'b0;
    #1;
    nvec++; if (ifa.fc_mem_timeout_o !== 1'b0) begin nerr++; $display("FAIL to_reset: got %b want 0", ifa.fc_mem_timeout_o); end
    do_reset();
  endtask

  task automatic test_mdu_branch();
    do_reset();
    next();
    ifa.mdu_start_i = 1'b1;
    @(negedge clk);
    nvec++; if (fa !== 6'b100010) begin nerr++; $display("FAIL mdu_start: got %b want 100010", fa); end
    for (int i = 1; i < 3; i++) begin
      next();
      ifa.ex_branch_taken_i = 1'b1; ifa.ex_branch_target_i = 32'h300;
      @(negedge clk);
      nvec++; if (fa !== 6'b100010) begin nerr++; $display("FAIL mdu_wait_c%0d: got %b want 100010", i, fa); end
    end
    next();
    ifa.mdu_done_i = 1'b1;
    @(negedge clk);
    nvec++; if (fa !== 6'b010101) begin nerr++; $display("FAIL mdu_done: got %b want 010101", fa); end
    nvec++; if (ifa.fc_redirect_pc_o !== 32'h300) begin nerr++; $display("FAIL mdu_done_pc: got %h want 300", ifa.fc_redirect_pc_o); end
    next(); idle();
    @(negedge clk);
    nvec++; if (fa !== 6'b000000) begin nerr++; $display("FAIL mdu_after: got %b want 000000", fa); end
    nvec++; if (ifa.fc_stall_cnt_o !== 32'd3) begin nerr++; $display("FAIL mdu_cnt: got %0d want 3", ifa.fc_stall_cnt_o); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      next();
      ifa.mem_req_i = 1'b1; ifa.mem_ready_i = 1'b0;
    end
    @(negedge clk);
    nvec++; if (fa !== 6'b100010) begin nerr++; $display("FAIL rmw_waiting: got %b want 100010", fa); end
    next();
    idle();
    rst_n = 1'b0;
    #1;
    nvec++; if (fa !== 6'b000000) begin nerr++; $display("FAIL rmw_flags: got %b want 000000", fa); end
    nvec++; if (ifa.fc_stall_cnt_o !== 32'd0) begin nerr++; $display("FAIL rmw_cnt: got %0d want 0", ifa.fc_stall_cnt_o); end
    nvec++; if (ifb.fc_stall_cnt_o !== 32'd0) begin nerr++; $display("FAIL rmw_cnt_b: got %0d want 0", ifb.fc_stall_cnt_o); end
    next();
    rst_n = 1'b1;
    @(negedge clk);
    nvec++; if (fa !== 6'b000000) begin nerr++; $display("FAIL rmw_run: got %b want 000000", fa); end
    nvec++; if (ifa.fc_stall_cnt_o !== 32'd0) begin nerr++; $display("FAIL rmw_cnt_after: got %0d want 0", ifa.fc_stall_cnt_o); end
    // to_cnt must restart from zero: 7 wait cycles stay below the 8-cycle limit
    for (int i = 0; i < 7; i++) begin
      next();
      ifa.mem_req_i = 1'b1; ifa.mem_ready_i = 1'b0;
    end
    next();
    ifa.mem_ready_i = 1'b1;
    @(negedge clk);
    nvec++; if (ifa.fc_mem_timeout_o !== 1'b0) begin nerr++; $display("FAIL rmw_to_restart: got %b want 0", ifa.fc_mem_timeout_o); end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch_vs_jump();
    test_mem_wait();
    test_timeout();
    test_mdu_branch();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/flow_ctrl.md
Name: flow_ctrl

Overview:
Pipeline flow controller ("fc") for the 5-stage in-order core. Generates the stall, flush, bubble and freeze flags consumed by the IF/ID, ID/EX and EX/MEM pipeline registers and the PC unit.
- Resolves load-use hazards, taken-branch redirects (EX), jump redirects (ID), data-memory wait states and multi-cycle MDU operations.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

Parameters:
LU_STALL, 1, load-use stall length in cycles (1..7)
MEM_TIMEOUT, 256, MEM_WAIT cycles before fc_mem_timeout_o sets (>=2)
CNT_W, 32, width of the stall-cycle counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
id_rs1_addr_i  in  5  ID source register 1
id_rs1_re_i  in  1  ID reads rs1
id_rs2_addr_i  in  5  ID source register 2
id_rs2_re_i  in  1  ID reads rs2
id_jump_i  in  1  ID has jal/jalr
id_jump_target_i  in  32  jump target
ex_is_load_i  in  1  EX holds a load
ex_rd_addr_i  in  5  EX destination register
ex_branch_taken_i  in  1  EX branch resolved taken
ex_branch_target_i  in  32  branch target
mem_req_i  in  1  MEM stage issuing a data access
mem_ready_i  in  1  data memory ready
mdu_start_i  in  1  EX starts a multi-cycle mul/div
mdu_done_i  in  1  MDU result valid
fc_stall_flag_o  out  1  hold PC and IF/ID
fc_flush_btype_flag_o  out  1  flush IF/ID, branch cause
fc_flush_jtype_flag_o  out  1  flush IF/ID, jump cause
fc_idex_bubble_o  out  1  load NOP into ID/EX
fc_freeze_ex_o  out  1  hold ID/EX and EX/MEM
fc_redirect_o  out  1  PC loads fc_redirect_pc_o
fc_redirect_pc_o  out  32  redirect target
fc_mem_timeout_o  out  1  sticky memory-timeout error
fc_stall_cnt_o  out  CNT_W  saturating stall-cycle count

Behaviour:
- Registered: state, lu_cnt (3b), to_cnt, fc_mem_timeout_o, fc_stall_cnt_o. All flag outputs are combinational from state plus inputs, so they take effect at the next clock edge.
- Reset values: state=RUN, counters 0, fc_mem_timeout_o=0. All combinational outputs are 0 while inputs are idle, and fc_redirect_pc_o=0 whenever fc_redirect_o=0.
- States: RUN, LOAD_USE, MEM_WAIT, MDU_WAIT.
- RUN, evaluated in this priority order (first match wins):
  1. mem_req_i & !mem_ready_i: stall=1, freeze_ex=1, no flush/redirect, to_cnt<=1, go to MEM_WAIT.
  2. ex_branch_taken_i: flush_btype=1, idex_bubble=1, redirect=1, pc=ex_branch_target_i.
  3. Load-use, where hz = ex_is_load_i & ex_rd_addr_i!=0 & ((id_rs1_re_i & rs1==rd) | (id_rs2_re_i & rs2==rd)): stall=1, idex_bubble=1. If LU_STALL>1, lu_cnt<=LU_STALL-1 and go to LOAD_USE.
  4. id_jump_i: flush_jtype=1, redirect=1, pc=id_jump_target_i.
  5. mdu_start_i & !mdu_done_i: stall=1, freeze_ex=1, go to MDU_WAIT.
- LOAD_USE: stall=1, idex_bubble=1, lu_cnt decrements. When lu_cnt==1, return to RUN after this cycle.
- MEM_WAIT: stall=1, freeze_ex=1, to_cnt increments (saturating).
  - When to_cnt reaches MEM_TIMEOUT, set fc_mem_timeout_o. It stays set until reset, and the FSM keeps waiting.
  - In the cycle mem_ready_i=1, outputs and next state are evaluated with RUN rules, which releases the pipe that cycle; to_cnt is cleared.
- MDU_WAIT: stall=1, freeze_ex=1. In the cycle mdu_done_i=1, RUN rules apply.
- Branch held in EX during a freeze: ex_branch_taken_i stays asserted because EX is frozen, and the flush is issued on release. No flush is ever issued while freeze_ex=1.
- flush_btype and flush_jtype are never both 1. The branch flush wins over the jump flush and over load-use.
- fc_stall_cnt_o increments on every cycle with fc_stall_flag_o=1 and saturates at all-ones.
- An rst_n assertion in any state returns immediately to the reset values.

Decomposition:
- Package fc_pkg holds the state enum (RUN=0, LOAD_USE=1, MEM_WAIT=2, MDU_WAIT=3) and the NOP-related constants shared with the pipeline registers.
- Sub-module fc_hazard_detect: combinational load-use comparator producing hz.
- The FSM, counters and output muxing stay in flow_ctrl.

Test Plan:
- Load-use: ex load rd=5, id rs1=5 re=1, LU_STALL=1 -> exactly 1 cycle of stall=1, bubble=1, then release. Repeat with rd=0 -> no stall.
- Branch vs jump: ex_branch_taken=1 target 0x100 with id_jump=1 target 0x200 in the same cycle -> flush_btype=1, flush_jtype=0, redirect_pc=0x100.
- Memory wait: mem_req=1, ready low for 4 cycles -> 4 cycles of stall+freeze, release in the ready cycle, stall_cnt=4.
- Timeout: MEM_TIMEOUT=8, ready never asserts -> fc_mem_timeout_o rises after 8 wait cycles and remains high after ready. Reset clears it.
- MDU with branch: mdu_start, done after 3 cycles while ex_branch_taken is held -> no flush during wait, flush_btype in the done cycle.
- Reset mid-MEM_WAIT: assert rst_n=0 -> all outputs 0 immediately. After release, state is RUN and the counters are 0.
